// File: rtl/uart_tx_frame.sv
// UART transmit framing stage: serialises start, LSB-first data, optional parity and stop.
// One CLK cycle is one bit period; busy/excep tell the parity calculator when a new byte is taken.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  excep
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state, w_next_state;
  logic [CNT_W-1:0]      r_cnt, w_next_cnt;
  logic [DATA_WIDTH-1:0] r_data, w_next_data;
  logic                  r_par_en, w_next_par_en;
  logic                  r_tx, w_next_tx;
  logic                  r_busy, w_next_busy;
  logic                  r_excep, w_next_excep;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_cnt_inc;

  // Same condition the parity calculator uses to latch, so both see the same byte.
  assign w_accept  = Data_Valid && (!r_busy || r_excep);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_data   = r_data;
    w_next_par_en = r_par_en;
    w_next_tx     = r_tx;
    w_next_busy   = r_busy;
    w_next_excep  = r_excep;

    case (r_state)
      S_IDLE: begin
        w_next_tx    = 1'b1;
        w_next_busy  = 1'b0;
        w_next_excep = 1'b0;
        if (w_accept) begin
          w_next_state  = S_START;
          w_next_data   = P_DATA;
          w_next_par_en = PAR_EN;
          w_next_cnt    = '0;
          w_next_tx     = 1'b0;
          w_next_busy   = 1'b1;
        end
      end
      S_START: begin
        w_next_state = S_DATA;
        w_next_cnt   = '0;
        w_next_tx    = r_data[0];
        w_next_busy  = 1'b1;
        w_next_excep = 1'b0;
      end
      S_DATA: begin
        w_next_busy  = 1'b1;
        w_next_excep = 1'b0;
        // The counter holds the index of the bit currently on the line.
        if (r_cnt == LAST_BIT) begin
          if (r_par_en) begin
            w_next_state = S_PARITY;
            w_next_tx    = par_bit;
          end else begin
            w_next_state = S_STOP;
            w_next_tx    = 1'b1;
            w_next_excep = 1'b1;
          end
        end else begin
          w_next_cnt = w_cnt_inc;
          w_next_tx  = r_data[w_cnt_inc];
        end
      end
      S_PARITY: begin
        w_next_state = S_STOP;
        w_next_tx    = 1'b1;
        w_next_busy  = 1'b1;
        w_next_excep = 1'b1;
      end
      S_STOP: begin
        if (w_accept) begin
          w_next_state  = S_START;
          w_next_data   = P_DATA;
          w_next_par_en = PAR_EN;
          w_next_cnt    = '0;
          w_next_tx     = 1'b0;
          w_next_busy   = 1'b1;
          w_next_excep  = 1'b0;
        end else begin
          w_next_state = S_IDLE;
          w_next_tx    = 1'b1;
          w_next_busy  = 1'b0;
          w_next_excep = 1'b0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
        w_next_tx    = 1'b1;
        w_next_busy  = 1'b0;
        w_next_excep = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_par_en <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_excep  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_data   <= w_next_data;
      r_par_en <= w_next_par_en;
      r_tx     <= w_next_tx;
      r_busy   <= w_next_busy;
      r_excep  <= w_next_excep;
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;
  assign excep  = r_excep;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed and random frames compared against a per-cycle
// model of the serial line built from the framing rules (start, LSB-first data, parity, stop).
module tb_uart_tx_frame;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         par_bit;
  logic         TX_OUT;
  logic         busy;
  logic         excep;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;
  int busyRun = 0;
  int maxBusyRun = 0;

  bit expTx[$];
  bit expBusy[$];
  bit expExcep[$];

  logic [W-1:0] rndData;
  logic         rndPe;
  logic         rndPb;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN),
    .par_bit(par_bit),
    .TX_OUT(TX_OUT),
    .busy(busy),
    .excep(excep)
  );

  always #5 CLK = ~CLK;

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic observed, input logic expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkInt(input string tag, input int observed, input int expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input bit eTx, input bit eBusy, input bit eExcep);
    checkValue({tag, ".tx"}, TX_OUT, eTx);
    checkValue({tag, ".busy"}, busy, eBusy);
    checkValue({tag, ".excep"}, excep, eExcep);
  endtask

  // A frame is the line sequence 0, data LSB first, optional parity, 1; busy throughout, excep on the stop bit.
  task automatic appendFrame(input logic [W-1:0] data, input bit parEn, input bit parBit);
    bit frame[$];
    frame.push_back(1'b0);
    for (int i = 0; i < W; i++) frame.push_back(data[i]);
    if (parEn) frame.push_back(parBit);
    frame.push_back(1'b1);
    for (int k = 0; k < frame.size(); k++) begin
      expTx.push_back(frame[k]);
      expBusy.push_back(1'b1);
      expExcep.push_back(k == frame.size() - 1);
    end
  endtask

  task automatic appendIdle(input int n);
    for (int i = 0; i < n; i++) begin
      expTx.push_back(1'b1);
      expBusy.push_back(1'b0);
      expExcep.push_back(1'b0);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input bit parEn, input bit parBit, input bit holdValid);
    P_DATA     = data;
    PAR_EN     = parEn;
    par_bit    = parBit;
    Data_Valid = 1'b1;
    stepCycle();
    if (!holdValid) begin
      Data_Valid = 1'b0;
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom);
    end
  endtask

  task automatic drainExpected(input string tag, input int dvOnIdx, input int dvOffIdx, input logic [W-1:0] pokeData);
    int i = 0;
    busyRun = 0;
    maxBusyRun = 0;
    while (expTx.size() > 0) begin
      checkOutput($sformatf("%s[%0d]", tag, i), expTx.pop_front(), expBusy.pop_front(), expExcep.pop_front());
      busyRun = (busy === 1'b1) ? busyRun + 1 : 0;
      if (busyRun > maxBusyRun) maxBusyRun = busyRun;
      if (i == dvOnIdx) begin
        Data_Valid = 1'b1;
        P_DATA     = pokeData;
      end
      if (i == dvOffIdx) Data_Valid = 1'b0;
      stepCycle();
      i++;
    end
  endtask

  initial begin
    RST        = 1'b0;
    Data_Valid = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    par_bit    = 1'b0;

    stepCycle();
    stepCycle();
    checkOutput("reset", 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    appendIdle(20);
    drainExpected("idle", -1, -1, '0);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
    appendFrame(8'hA5, 1'b1, 1'b0);
    appendIdle(2);
    drainExpected("par_A5", -1, -1, '0);

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    appendFrame(8'h3C, 1'b0, 1'b0);
    appendIdle(2);
    drainExpected("nopar_3C", -1, -1, '0);

    // Data_Valid stays high; the second byte is presented while the first frame is on its stop bit.
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b1);
    appendFrame(8'h01, 1'b0, 1'b0);
    appendFrame(8'hFF, 1'b0, 1'b0);
    appendIdle(2);
    drainExpected("b2b", 9, 10, 8'hFF);
    checkInt("b2b.busyRun", maxBusyRun, 20);

    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    appendFrame(8'h55, 1'b0, 1'b0);
    appendIdle(3);
    drainExpected("ignored", 3, 4, 8'h00);

    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
    appendFrame(8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("preReset[%0d]", i), expTx.pop_front(), expBusy.pop_front(), expExcep.pop_front());
      if (i == 4) RST = 1'b0;
      stepCycle();
    end
    expTx.delete();
    expBusy.delete();
    expExcep.delete();
    checkOutput("midReset", 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    stepCycle();
    checkOutput("postReset", 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h96, 1'b1, 1'b0, 1'b0);
    appendFrame(8'h96, 1'b1, 1'b0);
    appendIdle(1);
    drainExpected("afterReset", -1, -1, '0);

    for (int k = 0; k < 8; k++) begin
      rndData = W'($urandom);
      rndPe   = 1'($urandom_range(0, 1));
      rndPb   = 1'($urandom_range(0, 1));
      applyStimulus(rndData, rndPe, rndPb, 1'b0);
      appendFrame(rndData, rndPe, rndPb);
      appendIdle($urandom_range(1, 3));
      drainExpected($sformatf("rand%0d", k), -1, -1, '0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
